imem_responder: RTL and testbench

Instruction-memory responder for the single-issue RV64 core: it is the memory end of the fetch interface that the core's fetch stage drives with `inst_addr`/`inst_ena`. It holds program words in an internal word-addressed RAM, returns 32-bit instruction words after a fixed, parameterised latency, and flags misaligned or out-of-range fetches. A side load port lets the bench or boot logic write program words before or while the core runs.

---
 rtl/imem_responder.sv | 87 ++++++++
 tb/tb_imem_responder.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// Instruction-memory responder for the RV64 fetch port: word RAM with a side load port,
// fixed-latency registered responses, and NOP substitution for misaligned/out-of-range fetches.
module imem_responder #(
  parameter int          DEPTH     = 1024,
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000,
  parameter int          LATENCY   = 1,
  localparam int         AW        = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inst_ena,
  input  logic [63:0]   inst_addr,
  input  logic          load_we,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  output logic [31:0]   inst,
  output logic          inst_valid,
  output logic          inst_err,
  output logic [31:0]   fetch_cnt
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]        mem [DEPTH];
  logic [LATENCY-1:0] pipe_valid;
  logic [LATENCY-1:0] pipe_err;
  logic [31:0]        pipe_data [LATENCY];

  logic          borrow;
  logic [61:0]   off_word;
  logic          misaligned;
  logic          out_of_range;
  logic          fault;
  logic [AW-1:0] word_idx;

  // Word offset (inst_addr - BASE_ADDR) >> 2, computed on the word field plus the low-bit borrow.
  assign borrow       = inst_addr[1:0] < BASE_ADDR[1:0];
  assign off_word     = inst_addr[63:2] - BASE_ADDR[63:2] - {61'd0, borrow};
  assign misaligned   = |inst_addr[1:0];
  // The below-base check catches offsets that wrapped around to small values.
  assign out_of_range = (inst_addr < BASE_ADDR) || (off_word >= 62'(DEPTH));
  assign fault        = misaligned || out_of_range;
  assign word_idx     = off_word[AW-1:0];

  // RAM contents survive reset; reset only blocks writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
    end else if (load_we) begin
      mem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_valid <= '0;
      pipe_err   <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        pipe_data[k] <= NOP;
      end
      fetch_cnt <= '0;
    end else begin
      pipe_valid[0] <= inst_ena;
      if (inst_ena) begin
        fetch_cnt   <= fetch_cnt + 32'd1;
        pipe_err[0] <= fault;
        if (fault) begin
          pipe_data[0] <= NOP;
        end else begin
          pipe_data[0] <= mem[word_idx];
        end
      end
      // Bubbles advance as invalid entries without disturbing held data/err.
      for (int k = 1; k < LATENCY; k++) begin
        pipe_valid[k] <= pipe_valid[k-1];
        if (pipe_valid[k-1]) begin
          pipe_err[k]  <= pipe_err[k-1];
          pipe_data[k] <= pipe_data[k-1];
        end
      end
    end
  end

  assign inst       = pipe_data[LATENCY-1];
  assign inst_valid = pipe_valid[LATENCY-1];
  assign inst_err   = pipe_err[LATENCY-1];

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: one LATENCY=1 and one LATENCY=3 instance on shared stimulus.
module tb_imem_responder;

  localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;
  localparam int          DEP  = 1024;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        inst_ena;
  logic [63:0] inst_addr;
  logic        load_we;
  logic [9:0]  load_addr;
  logic [31:0] load_data;

  logic [31:0] inst1, inst3;
  logic        valid1, valid3;
  logic        err1, err3;
  logic [31:0] cnt1, cnt3;

  int checks = 0;
  int errors = 0;

  imem_responder #(.DEPTH(DEP), .BASE_ADDR(BASE), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst), .inst_ena(inst_ena), .inst_addr(inst_addr),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .inst(inst1), .inst_valid(valid1), .inst_err(err1), .fetch_cnt(cnt1)
  );

  imem_responder #(.DEPTH(DEP), .BASE_ADDR(BASE), .LATENCY(3)) u_lat3 (
    .clk(clk), .rst(rst), .inst_ena(inst_ena), .inst_addr(inst_addr),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .inst(inst3), .inst_valid(valid3), .inst_err(err3), .fetch_cnt(cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ena;
    logic [63:0] addr;
    logic        we;
    logic [9:0]  la;
    logic [31:0] ld;
    logic        ev;
    logic        ee;
    logic [31:0] ei;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic ena, logic [63:0] addr, logic we, int la, logic [31:0] ld,
                              logic ev, logic ee, logic [31:0] ei);
    vec_t v;
    v.ena = ena; v.addr = addr; v.we = we; v.la = 10'(la); v.ld = ld;
    v.ev = ev; v.ee = ee; v.ei = ei;
    return v;
  endfunction

  function automatic logic [63:0] wa(int i);
    return BASE + 64'(i) * 64'd4;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(string tag, logic [31:0] i1, logic v1, logic e1,
                          logic [31:0] i3, logic v3, logic e3, logic [31:0] c);
    chk({tag, " L1 inst"},  inst1, i1);
    chk({tag, " L1 valid"}, 32'(valid1), 32'(v1));
    chk({tag, " L1 err"},   32'(err1), 32'(e1));
    chk({tag, " L1 cnt"},   cnt1, c);
    chk({tag, " L3 inst"},  inst3, i3);
    chk({tag, " L3 valid"}, 32'(valid3), 32'(v3));
    chk({tag, " L3 err"},   32'(err3), 32'(e3));
    chk({tag, " L3 cnt"},   cnt3, c);
  endtask

  initial begin
    logic [31:0] exp_cnt;
    vec_t        d;

    rst = 1'b0; inst_ena = 1'b0; inst_addr = '0;
    load_we = 1'b0; load_addr = '0; load_data = '0;

    // Reset held, then idle after release.
    for (int c = 0; c < 3; c++) begin
      step();
      chk_outs($sformatf("rst%0d", c), NOP, 1'b0, 1'b0, NOP, 1'b0, 1'b0, 32'd0);
    end
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk_outs($sformatf("idle%0d", c), NOP, 1'b0, 1'b0, NOP, 1'b0, 1'b0, 32'd0);
    end

    // Stimulus table; expected columns describe the LATENCY=1 instance.
    for (int i = 0; i < 8; i++) tbl.push_back(mk(0, '0, 1, i, 32'h1000_0000 + 32'(i), 0, 0, NOP));
    tbl.push_back(mk(0, '0, 1, DEP-1, 32'hDEAD_BEEF, 0, 0, NOP));
    tbl.push_back(mk(0, '0, 1, 9, 32'hAAAA_AAAA, 0, 0, NOP));
    for (int i = 0; i < 8; i++) tbl.push_back(mk(1, wa(i), 0, 0, '0, 1, 0, 32'h1000_0000 + 32'(i)));
    tbl.push_back(mk(1, BASE + 64'd2, 0, 0, '0, 1, 1, NOP));
    tbl.push_back(mk(0, '0, 0, 0, '0, 0, 1, NOP));
    tbl.push_back(mk(1, BASE - 64'd4, 0, 0, '0, 1, 1, NOP));
    tbl.push_back(mk(1, wa(DEP), 0, 0, '0, 1, 1, NOP));
    tbl.push_back(mk(1, 64'h8000_0000_8000_0000, 0, 0, '0, 1, 1, NOP));
    tbl.push_back(mk(1, wa(DEP-1), 0, 0, '0, 1, 0, 32'hDEAD_BEEF));
    tbl.push_back(mk(1, wa(5), 0, 0, '0, 1, 0, 32'h1000_0005));
    tbl.push_back(mk(0, '0, 0, 0, '0, 0, 0, 32'h1000_0005));
    tbl.push_back(mk(1, wa(6), 0, 0, '0, 1, 0, 32'h1000_0006));
    tbl.push_back(mk(1, wa(7), 0, 0, '0, 1, 0, 32'h1000_0007));
    tbl.push_back(mk(0, '0, 0, 0, '0, 0, 0, 32'h1000_0007));
    tbl.push_back(mk(1, wa(9), 1, 9, 32'h5555_5555, 1, 0, 32'hAAAA_AAAA));
    tbl.push_back(mk(1, wa(9), 0, 0, '0, 1, 0, 32'h5555_5555));
    tbl.push_back(mk(0, '0, 0, 0, '0, 0, 0, 32'h5555_5555));
    tbl.push_back(mk(0, '0, 0, 0, '0, 0, 0, 32'h5555_5555));

    // The LATENCY=3 instance must show the LATENCY=1 row expectation two edges later.
    exp_cnt = '0;
    for (int i = 0; i < tbl.size(); i++) begin
      inst_ena  = tbl[i].ena;
      inst_addr = tbl[i].addr;
      load_we   = tbl[i].we;
      load_addr = tbl[i].la;
      load_data = tbl[i].ld;
      step();
      if (tbl[i].ena) exp_cnt = exp_cnt + 32'd1;
      if (i >= 2) d = tbl[i-2];
      else        d = mk(0, '0, 0, 0, '0, 0, 0, NOP);
      chk_outs($sformatf("row%0d", i), tbl[i].ei, tbl[i].ev, tbl[i].ee, d.ei, d.ev, d.ee, exp_cnt);
    end
    load_we = 1'b0;

    // Reset mid-flight: two requests in the LATENCY=3 pipe, reset pulsed between edges.
    inst_ena = 1'b1; inst_addr = wa(0);
    step();
    chk("mid1 L1 inst", inst1, 32'h1000_0000);
    chk("mid1 L3 valid", 32'(valid3), 32'd0);
    inst_addr = wa(1);
    step();
    chk("mid2 L1 inst", inst1, 32'h1000_0001);
    chk("mid2 L3 valid", 32'(valid3), 32'd0);
    inst_ena = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk_outs("midrst", NOP, 1'b0, 1'b0, NOP, 1'b0, 1'b0, 32'd0);
    #1 rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk_outs($sformatf("post%0d", c), NOP, 1'b0, 1'b0, NOP, 1'b0, 1'b0, 32'd0);
    end

    // Loads during reset are dropped; RAM contents persist through reset.
    rst = 1'b0; load_we = 1'b1; load_addr = 10'd9; load_data = 32'h0BAD_0BAD;
    step();
    step();
    load_we = 1'b0; rst = 1'b1;
    inst_ena = 1'b1; inst_addr = wa(9);
    step();
    inst_ena = 1'b0;
    chk("keep L1 inst", inst1, 32'h5555_5555);
    chk("keep L1 valid", 32'(valid1), 32'd1);
    chk("keep cnt", cnt1, 32'd1);
    step();
    chk("keep L3 early valid", 32'(valid3), 32'd0);
    step();
    chk("keep L3 inst", inst3, 32'h5555_5555);
    chk("keep L3 valid", 32'(valid3), 32'd1);
    chk("keep L3 err", 32'(err3), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
